alu_ctrl_mdu: RTL and testbench
===============================

ALU_CTRL_MDU -- requirements
Module: alu_ctrl_mdu

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ALUOp  in  2  from main control: 00 add (lw/sw/addi), 01 sub (beq/bne), 10 R-type (use funct), 11 and (andi).
REQ-005 funct  in  6  instruction funct field, EX stage.
REQ-006 valid  in  1  EX-stage instruction is real; 0 means bubble.
REQ-007 ReadData1  in  32  rs operand; ReadData2  in  32  rt operand.
REQ-008 ALUcontrol  out  4  operation code driven to the ALU.
REQ-009 Stall  out  1  freeze PC, IF/ID and ID/EX; insert bubble into EX/MEM.
REQ-010 MDresult  out  32  HI or LO value for mfhi/mflo.
REQ-011 MDsel  out  1  EX result mux selects MDresult instead of ALU output.

Function
REQ-012 ALUcontrol SHALL be combinational: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt, 1111 all other cases, including mult/multu/div/divu/mfhi/mflo and undefined funct.
REQ-013 R-type funct decode SHALL be: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 011000 mult, 011001 multu, 010000 mfhi, 010010 mflo.
REQ-014 ALUcontrol SHALL depend only on ALUOp/funct and be unaffected by valid or Stall.
REQ-015 FSM states SHALL be IDLE, MUL, and DIV when the divide feature is compiled in.
REQ-016 Accept: in IDLE, on an edge with valid=1, ALUOp=10 and a mult-class funct, the block SHALL latch operands and cycle counter=0 and move to MUL (or DIV).
REQ-017 Iteration: the block SHALL perform one shift-add (or one restore-subtract) step per edge over 32 edges after accept.
REQ-018 On the 32nd iteration edge it SHALL write HI/LO and return to IDLE.
REQ-019 mult SHALL compute the signed 64-bit product; multu the unsigned product; HI = bits 63:32, LO = bits 31:0.
REQ-020 Signed mult SHALL iterate on magnitudes and negate the 64-bit result when the operand signs differ.
REQ-021 Stall SHALL be 1 while not IDLE and valid=1, ALUOp=10, and funct is mfhi, mflo, or any mult/div-class code; Stall SHALL be 0 otherwise.
REQ-022 No stall SHALL occur at accept itself; independent instructions proceed during iteration.
REQ-023 A mult-class instruction stalled by a busy unit SHALL be accepted on the first edge after the unit returns to IDLE.
REQ-024 MDresult SHALL be HI for mfhi and LO for mflo, combinationally.
REQ-025 MDsel SHALL be valid & ALUOp=10 & (mfhi|mflo) & !Stall.
REQ-026 A bubble (valid=0) SHALL never start an operation or cause Stall.

Reset
REQ-027 While reset=1 on an edge, the block SHALL set FSM=IDLE, counter=0, HI=0, LO=0, and clear operand registers.
REQ-028 Stall SHALL be 0 the cycle after reset.
REQ-029 Reset mid-operation SHALL abort with no HI/LO update.
REQ-030 Reset SHALL take priority over accept on the same edge.

Configuration
REQ-031 With MDU_DIV_EN defined, the block SHALL add div (011010) and divu (011011) using a 32-step restoring divider: LO=quotient, HI=remainder.
REQ-032 Signed div SHALL give the quotient sign = XOR of operand signs and the remainder sign = dividend sign.
REQ-033 Divide by zero SHALL give LO=FFFFFFFF and HI=dividend, still taking 32 cycles.
REQ-034 Without MDU_DIV_EN, funct 011010/011011 SHALL decode as undefined: ALUcontrol=1111, no accept, no Stall, and no DIV state.

Structure
REQ-035 Shared package alu_pkg SHALL hold the ALUcontrol code constants, ALUOp constants, funct constants and FSM state encoding, so the ALU and control use identical codes.
REQ-036 Iterative datapath (accumulator, shift, restore-subtract, counter) SHALL live in one sub-module mdu_iter; alu_ctrl_mdu holds the decode, FSM/stall logic and HI/LO.

Verification
REQ-037 Decode sweep: ALUOp=10 with funct 100000/100010/100100/100101/101010 -> ALUcontrol 0000/0001/0010/0011/0100; ALUOp=00/01/11 -> 0000/0001/0010; funct 001000 -> 1111.
REQ-038 mult 7 x FFFFFFFD, then mflo issued the next cycle -> Stall=1 for 32 cycles, then MDsel=1 with MDresult=FFFFFFEB; mfhi -> FFFFFFFF.
REQ-039 multu FFFFFFFF x FFFFFFFF -> HI=FFFFFFFE, LO=00000001; an add issued during iteration sees Stall=0.
REQ-040 Back-to-back mult/mult -> the second stalls until IDLE, is accepted on the next edge, and the final HI/LO reflect the second.
REQ-041 reset asserted at iteration 10 of mult 5x5 -> the cycle after, HI=LO=0, Stall=0, and a subsequent mflo returns 0.
REQ-042 With MDU_DIV_EN: div FFFFFFF9 / 2 -> LO=FFFFFFFD, HI=FFFFFFFF; divu 10 / 0 -> LO=FFFFFFFF, HI=0000000A.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, ALUOp/funct encodings and MDU state encoding.
// The DIV state exists only when MDU_DIV_EN is defined.
package alu_pkg;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_BAD = 4'b1111;
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_AND   = 2'b11;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  typedef enum logic [1:0] {
    IDLE,
`ifdef MDU_DIV_EN
    DIV,
`endif
    MUL
  } state_t;
endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: 32-step shift-add multiplier / restoring divider datapath with sign fix-up.
// Ports: clk, rst; start latches a/b (div, sgn select op); run advances one step;
// last flags the final step; hi/lo give the fixed-up result of the step now taking place.
module mdu_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        div,
  input  logic        sgn,
  input  logic        run,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        last,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  logic [63:0] acc, acc_nxt, prod;
  logic [31:0] m, ma, mb;
  logic [32:0] sum, t, diff;
  logic [4:0]  cnt;
  logic        is_div, neg_q, neg_r, zero;
  assign ma = sgn && a[31] ? -a : a;
  assign mb = sgn && b[31] ? -b : b;
  // multiply: {carry, upper+m} shifted right; divide: {rem, quot} shifted left with trial subtract
  assign sum = {1'b0, acc[63:32]} + {1'b0, acc[0] ? m : 32'd0};
  assign t = {acc[63:32], acc[31]};
  assign diff = t - {1'b0, m};
  assign acc_nxt = is_div ? (diff[32] ? {t[31:0], acc[30:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1})
                          : {sum, acc[31:1]};
  assign prod = neg_q ? -acc_nxt : acc_nxt;
  assign last = cnt == 5'd31;
  // divide by zero leaves the raw all-ones quotient, skipping the sign fix
  assign lo = is_div ? (zero ? 32'hFFFF_FFFF : neg_q ? -acc_nxt[31:0] : acc_nxt[31:0]) : prod[31:0];
  assign hi = is_div ? (neg_r ? -acc_nxt[63:32] : acc_nxt[63:32]) : prod[63:32];
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      m <= '0;
      cnt <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      zero <= 1'b0;
    end else if (start) begin
      acc <= {32'd0, div ? ma : mb};
      m <= div ? mb : ma;
      cnt <= '0;
      is_div <= div;
      neg_q <= sgn & (a[31] ^ b[31]);
      neg_r <= sgn & a[31];
      zero <= b == 32'd0;
    end else if (run) begin
      acc <= acc_nxt;
      cnt <= cnt + 5'd1;
    end
  end
endmodule

// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu: ALU control decode plus iterative mult/div unit with HI/LO and pipeline stall.
// Ports: clk, reset (sync, active-high); ALUOp, funct, valid, ReadData1/2 in;
// ALUcontrol, Stall, MDresult, MDsel out. Define MDU_DIV_EN to add div/divu.
module alu_ctrl_mdu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  ALUOp,
  input  logic [5:0]  funct,
  input  logic        valid,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  output logic [3:0]  ALUcontrol,
  output logic        Stall,
  output logic [31:0] MDresult,
  output logic        MDsel
);
  state_t state, state_nxt;
  logic [31:0] hi, lo, it_hi, it_lo;
  logic rtype, is_mul, is_div, is_mv, accept, last;
  assign rtype = valid && ALUOp == OP_RTYPE;
  assign is_mul = funct == F_MULT || funct == F_MULTU;
`ifdef MDU_DIV_EN
  assign is_div = funct == F_DIV || funct == F_DIVU;
`else
  assign is_div = 1'b0;
`endif
  assign is_mv = funct == F_MFHI || funct == F_MFLO;
  assign accept = state == IDLE && rtype && (is_mul || is_div);
  assign Stall = state != IDLE && rtype && (is_mul || is_div || is_mv);
  assign MDsel = rtype && is_mv && !Stall;
  assign MDresult = funct == F_MFLO ? lo : hi;
  always_comb begin
    ALUcontrol = ALUOp == OP_ADD ? ALU_ADD :
                 ALUOp == OP_SUB ? ALU_SUB :
                 ALUOp == OP_AND ? ALU_AND :
                 funct == F_ADD  ? ALU_ADD :
                 funct == F_SUB  ? ALU_SUB :
                 funct == F_AND  ? ALU_AND :
                 funct == F_OR   ? ALU_OR  :
                 funct == F_SLT  ? ALU_SLT : ALU_BAD;
  end
  always_comb begin
    state_nxt = state;
    if (accept)
`ifdef MDU_DIV_EN
      state_nxt = is_div ? DIV : MUL;
`else
      state_nxt = MUL;
`endif
    else if (state != IDLE && last)
      state_nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : state_nxt;
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state != IDLE && last) begin
      hi <= it_hi;
      lo <= it_lo;
    end
  end
  mdu_iter u_iter (
    .clk(clk),
    .rst(reset),
    .start(accept),
    .div(is_div),
    .sgn(funct == F_MULT || funct == F_DIV),
    .run(state != IDLE),
    .a(ReadData1),
    .b(ReadData2),
    .last(last),
    .hi(it_hi),
    .lo(it_lo)
  );
endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// tb_alu_ctrl_mdu: directed and random checks of alu_ctrl_mdu against a cycle-count reference model.
module tb_alu_ctrl_mdu;
  import alu_pkg::*;
`ifdef MDU_DIV_EN
  localparam bit DIVEN = 1'b1;
`else
  localparam bit DIVEN = 1'b0;
`endif
  logic clk = 1'b0, reset, valid, Stall, MDsel;
  logic [1:0] ALUOp;
  logic [5:0] funct;
  logic [31:0] ReadData1, ReadData2, MDresult;
  logic [3:0] ALUcontrol;
  int n_cmp = 0, n_err = 0;
  int busy = 0;
  logic [31:0] mhi = '0, mlo = '0, phi, plo;
  logic st_seen, sel_seen;
  logic [31:0] res_seen;
  logic [3:0] alu_seen;

  alu_ctrl_mdu dut (
    .clk(clk), .reset(reset), .ALUOp(ALUOp), .funct(funct), .valid(valid),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .ALUcontrol(ALUcontrol),
    .Stall(Stall), .MDresult(MDresult), .MDsel(MDsel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference result computed with plain 64-bit arithmetic
  task automatic md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sp, sq, sr;
    logic [63:0] up;
    if (f == F_MULT) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      {phi, plo} = sp;
    end else if (f == F_MULTU) begin
      up = {32'd0, a} * {32'd0, b};
      {phi, plo} = up;
    end else if (b == 32'd0) begin
      plo = 32'hFFFF_FFFF;
      phi = a;
    end else if (f == F_DIV) begin
      sq = longint'($signed(a)) / longint'($signed(b));
      sr = longint'($signed(a)) % longint'($signed(b));
      plo = sq[31:0];
      phi = sr[31:0];
    end else begin
      plo = a / b;
      phi = a % b;
    end
  endtask

  task automatic cyc(input logic r, input logic [1:0] op, input logic [5:0] f, input logic v,
                     input logic [31:0] a, input logic [31:0] b);
    logic rt, mc, mv, es, el;
    logic [3:0] ea;
    reset = r; ALUOp = op; funct = f; valid = v; ReadData1 = a; ReadData2 = b;
    #2;
    rt = v && op == 2'b10;
    mc = f == F_MULT || f == F_MULTU || (DIVEN && (f == F_DIV || f == F_DIVU));
    mv = f == F_MFHI || f == F_MFLO;
    es = busy > 0 && rt && (mc || mv);
    el = rt && mv && !es;
    case (op)
      2'b00: ea = 4'h0;
      2'b01: ea = 4'h1;
      2'b11: ea = 4'h2;
      default: case (f)
        6'b100000: ea = 4'h0;
        6'b100010: ea = 4'h1;
        6'b100100: ea = 4'h2;
        6'b100101: ea = 4'h3;
        6'b101010: ea = 4'h4;
        default:   ea = 4'hF;
      endcase
    endcase
    check("alu", {60'd0, ALUcontrol}, {60'd0, ea});
    check("stall", {63'd0, Stall}, {63'd0, es});
    check("mdsel", {63'd0, MDsel}, {63'd0, el});
    if (mv) check("mdres", {32'd0, MDresult}, {32'd0, f == F_MFLO ? mlo : mhi});
    st_seen = Stall; sel_seen = MDsel; res_seen = MDresult; alu_seen = ALUcontrol;
    @(posedge clk);
    if (r) begin
      busy = 0; mhi = '0; mlo = '0;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) begin mhi = phi; mlo = plo; end
    end else if (rt && mc) begin
      busy = 32;
      md(f, a, b);
    end
    #1;
  endtask

  task automatic rt(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    cyc(1'b0, 2'b10, f, 1'b1, a, b);
  endtask

  // repeat an R-type until it issues without stall; n = stalled cycles
  task automatic run(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      rt(f, a, b);
      if (!st_seen) break;
      n++;
    end
  endtask

  logic [5:0] fl [12] = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_MULT, F_MULTU,
                          F_DIV, F_DIVU, F_MFHI, F_MFLO, 6'b001000};
  logic [31:0] cv [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
  logic [5:0] sw_f [6] = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, 6'b001000};
  logic [3:0] sw_e [6] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hF};

  function automatic logic [31:0] rnd_op();
    return $urandom_range(0, 3) == 0 ? cv[$urandom_range(0, 4)] : $urandom;
  endfunction

  initial begin
    int n;
    reset = 1'b1; ALUOp = 2'b00; funct = '0; valid = 1'b0; ReadData1 = '0; ReadData2 = '0;
    @(posedge clk); #1;
    cyc(1'b1, 2'b00, 6'd0, 1'b0, 0, 0);
    rt(F_MFLO, 0, 0);
    check("rst_stall", {63'd0, st_seen}, 64'd0);
    check("rst_lo", {32'd0, res_seen}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      rt(sw_f[i], 0, 0);
      check("sweep", {60'd0, alu_seen}, {60'd0, sw_e[i]});
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, i == 2 ? 2'b11 : 2'(i), F_OR, 1'b1, 0, 0);
      check("aluop", {60'd0, alu_seen}, 64'(i));
    end
    rt(F_MULT, 32'd7, 32'hFFFF_FFFD);
    run(F_MFLO, 0, 0, n);
    check("mult_stall_len", 64'(n), 64'd32);
    check("mult_sel", {63'd0, sel_seen}, 64'd1);
    check("mult_lo", {32'd0, res_seen}, 64'hFFFF_FFEB);
    rt(F_MFHI, 0, 0);
    check("mult_hi", {32'd0, res_seen}, 64'hFFFF_FFFF);
    rt(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cyc(1'b0, 2'b00, 6'd0, 1'b1, 1, 2);
    check("indep_nostall", {63'd0, st_seen}, 64'd0);
    run(F_MFHI, 0, 0, n);
    check("multu_hi", {32'd0, res_seen}, 64'hFFFF_FFFE);
    rt(F_MFLO, 0, 0);
    check("multu_lo", {32'd0, res_seen}, 64'h1);
    rt(F_MULT, 32'd3, 32'd4);
    run(F_MULT, 32'hFFFF_FFFE, 32'd6, n);
    check("b2b_stall_len", 64'(n), 64'd32);
    run(F_MFLO, 0, 0, n);
    check("b2b_lo", {32'd0, res_seen}, 64'hFFFF_FFF4);
    rt(F_MFHI, 0, 0);
    check("b2b_hi", {32'd0, res_seen}, 64'hFFFF_FFFF);
    rt(F_MULT, 32'd5, 32'd5);
    for (int i = 0; i < 9; i++) cyc(1'b0, 2'b00, 6'd0, 1'b1, 0, 0);
    cyc(1'b1, 2'b00, 6'd0, 1'b0, 0, 0);
    rt(F_MFLO, 0, 0);
    check("abort_stall", {63'd0, st_seen}, 64'd0);
    check("abort_lo", {32'd0, res_seen}, 64'd0);
    rt(F_MFHI, 0, 0);
    check("abort_hi", {32'd0, res_seen}, 64'd0);
    cyc(1'b0, 2'b10, F_MULT, 1'b0, 32'd9, 32'd9);
    rt(F_MFLO, 0, 0);
    check("bubble_nostart", {63'd0, st_seen}, 64'd0);
`ifdef MDU_DIV_EN
    rt(F_DIV, 32'hFFFF_FFF9, 32'd2);
    run(F_MFLO, 0, 0, n);
    check("div_lo", {32'd0, res_seen}, 64'hFFFF_FFFD);
    rt(F_MFHI, 0, 0);
    check("div_hi", {32'd0, res_seen}, 64'hFFFF_FFFF);
    rt(F_DIVU, 32'd10, 32'd0);
    run(F_MFLO, 0, 0, n);
    check("divz_len", 64'(n), 64'd32);
    check("divz_lo", {32'd0, res_seen}, 64'hFFFF_FFFF);
    rt(F_MFHI, 0, 0);
    check("divz_hi", {32'd0, res_seen}, 64'hA);
`else
    rt(F_DIV, 32'd10, 32'd3);
    rt(F_MFLO, 0, 0);
    check("nodiv_stall", {63'd0, st_seen}, 64'd0);
`endif
    for (int i = 0; i < 4000; i++) begin
      logic [5:0] f;
      f = $urandom_range(0, 4) == 0 ? 6'($urandom) : fl[$urandom_range(0, 11)];
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0 ? 2'($urandom) : 2'b10, f,
          $urandom_range(0, 4) != 0, rnd_op(), rnd_op());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
